// File: rtl/gol_frame_scheduler_if.sv
// Handshake between the frame scheduler and the Game-of-Life update engine.
// The scheduler launches generations and arbitrates grid-memory access.
interface gol_frame_scheduler_if;
  logic gen_start;  // one-cycle launch pulse to the engine
  logic gen_busy;   // generation in flight (gen_start .. gen_done)
  logic gen_done;   // one-cycle pulse from the engine, generation written
  logic eng_req;    // engine wants the grid memory this cycle
  logic eng_gnt;    // engine owns the grid memory this cycle

  modport master (
    output gen_start, gen_busy, eng_gnt,
    input  gen_done, eng_req
  );

  modport slave (
    input  gen_start, gen_busy, eng_gnt,
    output gen_done, eng_req
  );
endinterface

// File: rtl/gol_frame_scheduler.sv
// Frame-locked scheduler for the Game-of-Life update engine.
// Launches a generation on a vsync-derived frame tick (free-running at a
// programmable frames-per-generation rate, or single-step), and flips the
// display/engine double buffer only on a frame tick so the display never
// tears mid-frame.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | nothing in flight, waiting for a trigger on a frame tick
// S_START    | gen_start pulse to the engine (single cycle)
// S_BUSY     | engine computing into eng_buf; may be granted memory
// S_SWAP_WAIT| generation written, waiting for the next frame tick to swap
module gol_frame_scheduler #(
  parameter int SPEED_W = 4,
  parameter int GEN_W   = 16
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic                 vsync,
  input  logic                 inside_video,
  input  logic                 run,
  input  logic                 step,
  input  logic [SPEED_W-1:0]   speed,
  gol_frame_scheduler_if.master eng,
  output logic                 disp_buf,
  output logic                 eng_buf,
  output logic [GEN_W-1:0]     generation,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_BUSY      = 2'd2,
    S_SWAP_WAIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 vsync_q;
  logic                 step_pending_q, step_pending_d;
  logic [SPEED_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 disp_buf_q, disp_buf_d;
  logic [GEN_W-1:0]     generation_q, generation_d;
  logic                 overrun_q, overrun_d;

  logic frame_tick;
  logic cnt_match;
  logic trigger;
  logic in_flight;
  logic take;
  logic swap;
  logic gen_start;
  logic gen_busy;

  // Falling edge of the active-low vsync; vsync_q resets low so reset
  // release with vsync already low never produces a tick.
  assign frame_tick = vsync_q & ~vsync;
  assign cnt_match  = (frame_cnt_q == speed);
  assign trigger    = frame_tick & (step_pending_q | (run & cnt_match));
  assign in_flight  = (state_q == S_START) || (state_q == S_BUSY);

  // Next-state and Moore outputs; take marks a trigger actually consumed.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    swap      = 1'b0;
    gen_start = 1'b0;
    gen_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_START;
          take    = 1'b1;
        end
      end
      S_START: begin
        gen_start = 1'b1;
        gen_busy  = 1'b1;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        gen_busy = 1'b1;
        // A gen_done landing on a frame tick still waits for the next tick.
        if (eng.gen_done) state_d = S_SWAP_WAIT;
      end
      S_SWAP_WAIT: begin
        if (frame_tick) begin
          swap = 1'b1;
          if (trigger) begin
            state_d = S_START;
            take    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: step latch, frame divider, buffer swap, counters.
  always_comb begin
    step_pending_d = step | (step_pending_q & ~take);
    frame_cnt_d    = frame_cnt_q;
    if (take)
      frame_cnt_d = '0;
    else if (frame_tick && run && !in_flight)
      frame_cnt_d = frame_cnt_q + 1'b1;
    disp_buf_d   = disp_buf_q ^ swap;
    generation_d = generation_q + GEN_W'(swap);
    overrun_d    = overrun_q | (frame_tick & run & cnt_match & in_flight);
  end

  // All state registers, asynchronously cleared by reset_n.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      vsync_q        <= 1'b0;
      step_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
      disp_buf_q     <= 1'b0;
      generation_q   <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync;
      step_pending_q <= step_pending_d;
      frame_cnt_q    <= frame_cnt_d;
      disp_buf_q     <= disp_buf_d;
      generation_q   <= generation_d;
      overrun_q      <= overrun_d;
    end
  end

  // Display always owns the grid memory during active video.
  assign eng.eng_gnt   = eng.eng_req & ~inside_video & (state_q == S_BUSY);
  assign eng.gen_start = gen_start;
  assign eng.gen_busy  = gen_busy;

  assign disp_buf   = disp_buf_q;
  assign eng_buf    = ~disp_buf_q;
  assign generation = generation_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_gol_frame_scheduler.sv
// Directed bench for gol_frame_scheduler: 200-cycle frames (vsync low for
// the first 4 cycles), behavioural engine answering gen_start after
// eng_delay cycles.
module tb_gol_frame_scheduler;
  localparam int SPEED_W = 4;
  localparam int GEN_W   = 16;
  localparam int FRAME   = 200;

  logic               pixel_clk = 1'b0;
  logic               reset_n;
  logic               vsync;
  logic               inside_video;
  logic               run;
  logic               step;
  logic [SPEED_W-1:0] speed;
  logic               disp_buf;
  logic               eng_buf;
  logic [GEN_W-1:0]   generation;
  logic               overrun;

  gol_frame_scheduler_if eif();

  gol_frame_scheduler #(.SPEED_W(SPEED_W), .GEN_W(GEN_W)) dut (
    .pixel_clk    (pixel_clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .inside_video (inside_video),
    .run          (run),
    .step         (step),
    .speed        (speed),
    .eng          (eif),
    .disp_buf     (disp_buf),
    .eng_buf      (eng_buf),
    .generation   (generation),
    .overrun      (overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks    = 0;
  int errors    = 0;
  int nstarts   = 0;
  int eng_cnt   = 0;
  int eng_delay = 100;

  // Engine model: pulse gen_done eng_delay cycles after each gen_start.
  initial begin
    eif.gen_done = 1'b0;
    forever begin
      @(negedge pixel_clk);
      eif.gen_done = 1'b0;
      if (!reset_n) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eif.gen_done = 1'b1;
        end
        if (eif.gen_start) begin
          eng_cnt = eng_delay;
          nstarts++;
        end
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    vsync = 1'b1; inside_video = 1'b0; run = 1'b0; step = 1'b0;
    speed = '0; eif.eng_req = 1'b0;
    repeat (3) @(negedge pixel_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge pixel_clk);
  endtask

  task automatic do_frame(input int step_at);
    for (int i = 0; i < FRAME; i++) begin
      vsync        = (i >= 4);
      inside_video = (i >= 20 && i < 180);
      step         = (i == step_at);
      @(negedge pixel_clk);
    end
    step = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (eif.gen_busy !== 1'b0) begin errors++; $display("FAIL reset_gen_busy got %b exp 0", eif.gen_busy); end
    checks++; if (eif.gen_start !== 1'b0) begin errors++; $display("FAIL reset_gen_start got %b exp 0", eif.gen_start); end
    checks++; if (eif.eng_gnt !== 1'b0) begin errors++; $display("FAIL reset_eng_gnt got %b exp 0", eif.eng_gnt); end
    checks++; if (disp_buf !== 1'b0) begin errors++; $display("FAIL reset_disp_buf got %b exp 0", disp_buf); end
    checks++; if (eng_buf !== 1'b1) begin errors++; $display("FAIL reset_eng_buf got %b exp 1", eng_buf); end
    checks++; if (generation !== 16'd0) begin errors++; $display("FAIL reset_generation got %0d exp 0", generation); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_free_run();
    int n0;
    apply_reset();
    eng_delay = 100; run = 1'b1; speed = 4'd0;
    n0 = nstarts;
    for (int k = 1; k <= 4; k++) begin
      do_frame(-1);
      checks++; if (nstarts - n0 !== k) begin errors++; $display("FAIL free_starts frame %0d got %0d exp %0d", k, nstarts - n0, k); end
      checks++; if (generation !== GEN_W'(k - 1)) begin errors++; $display("FAIL free_generation frame %0d got %0d exp %0d", k, generation, k - 1); end
      checks++; if (disp_buf !== 1'((k - 1) & 1)) begin errors++; $display("FAIL free_disp_buf frame %0d got %b exp %0d", k, disp_buf, (k - 1) & 1); end
      checks++; if (eng_buf !== ~disp_buf) begin errors++; $display("FAIL free_eng_buf frame %0d got %b disp %b", k, eng_buf, disp_buf); end
      checks++; if (eif.gen_busy !== 1'b0) begin errors++; $display("FAIL free_busy_after_done frame %0d got %b exp 0", k, eif.gen_busy); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL free_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_step();
    int n0;
    int exp_starts[4] = '{0, 1, 1, 1};
    int exp_gen[4]    = '{0, 0, 1, 1};
    apply_reset();
    eng_delay = 100; run = 1'b0; speed = 4'd0;
    n0 = nstarts;
    for (int k = 0; k < 4; k++) begin
      do_frame(k == 0 ? 100 : -1);
      checks++; if (nstarts - n0 !== exp_starts[k]) begin errors++; $display("FAIL step_starts frame %0d got %0d exp %0d", k, nstarts - n0, exp_starts[k]); end
      checks++; if (generation !== GEN_W'(exp_gen[k])) begin errors++; $display("FAIL step_generation frame %0d got %0d exp %0d", k, generation, exp_gen[k]); end
      checks++; if (disp_buf !== 1'(exp_gen[k])) begin errors++; $display("FAIL step_disp_buf frame %0d got %b exp %0d", k, disp_buf, exp_gen[k]); end
    end
  endtask

  task automatic test_speed2();
    int n0;
    apply_reset();
    eng_delay = 100; run = 1'b1; speed = 4'd2;
    n0 = nstarts;
    for (int k = 1; k <= 10; k++) begin
      do_frame(-1);
      checks++; if (nstarts - n0 !== k / 3) begin errors++; $display("FAIL speed2_starts frame %0d got %0d exp %0d", k, nstarts - n0, k / 3); end
    end
    checks++; if (generation !== 16'd3) begin errors++; $display("FAIL speed2_generation got %0d exp 3", generation); end
    checks++; if (disp_buf !== 1'b1) begin errors++; $display("FAIL speed2_disp_buf got %b exp 1", disp_buf); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL speed2_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_overrun();
    logic exp_ovr[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_disp[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    eng_delay = 450; run = 1'b1; speed = 4'd0;
    for (int k = 0; k < 4; k++) begin
      do_frame(-1);
      checks++; if (overrun !== exp_ovr[k]) begin errors++; $display("FAIL overrun_flag frame %0d got %b exp %b", k, overrun, exp_ovr[k]); end
      checks++; if (disp_buf !== exp_disp[k]) begin errors++; $display("FAIL overrun_disp_buf frame %0d got %b exp %b", k, disp_buf, exp_disp[k]); end
    end
    checks++; if (generation !== 16'd1) begin errors++; $display("FAIL overrun_generation got %0d exp 1", generation); end
    eng_delay = 100;
  endtask

  task automatic test_grant();
    apply_reset();
    eng_delay = 150; run = 1'b0; speed = 4'd0;
    eif.eng_req = 1'b1;
    @(negedge pixel_clk);
    checks++; if (eif.eng_gnt !== 1'b0) begin errors++; $display("FAIL grant_idle got %b exp 0", eif.eng_gnt); end
    step = 1'b1;
    @(negedge pixel_clk);
    step = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      vsync        = (i >= 4);
      inside_video = (i >= 20 && i < 60);
      @(negedge pixel_clk);
      if (i == 10) begin
        checks++; if (eif.gen_busy !== 1'b1) begin errors++; $display("FAIL grant_busy got %b exp 1", eif.gen_busy); end
        checks++; if (eif.eng_gnt !== 1'b1) begin errors++; $display("FAIL grant_blank got %b exp 1", eif.eng_gnt); end
      end
      if (i == 40) begin
        checks++; if (eif.eng_gnt !== 1'b0) begin errors++; $display("FAIL grant_video got %b exp 0", eif.eng_gnt); end
      end
      if (i == 100) begin
        checks++; if (eif.eng_gnt !== 1'b1) begin errors++; $display("FAIL grant_blank2 got %b exp 1", eif.eng_gnt); end
      end
      if (i == 190) begin
        checks++; if (eif.eng_gnt !== 1'b0) begin errors++; $display("FAIL grant_swap_wait got %b exp 0", eif.eng_gnt); end
      end
    end
    eif.eng_req = 1'b0;
    eng_delay = 100;
  endtask

  task automatic test_reset_busy();
    int n0;
    apply_reset();
    eng_delay = 100; run = 1'b1; speed = 4'd0;
    do_frame(-1);
    do_frame(-1);
    checks++; if (generation !== 16'd1) begin errors++; $display("FAIL rbusy_pre_generation got %0d exp 1", generation); end
    eif.eng_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vsync        = (i >= 4);
      inside_video = 1'b0;
      @(negedge pixel_clk);
    end
    checks++; if (eif.eng_gnt !== 1'b1) begin errors++; $display("FAIL rbusy_pre_gnt got %b exp 1", eif.eng_gnt); end
    reset_n = 1'b0;
    vsync   = 1'b0;
    #1;
    checks++; if (eif.gen_busy !== 1'b0) begin errors++; $display("FAIL rbusy_gen_busy got %b exp 0", eif.gen_busy); end
    checks++; if (eif.eng_gnt !== 1'b0) begin errors++; $display("FAIL rbusy_eng_gnt got %b exp 0", eif.eng_gnt); end
    checks++; if (disp_buf !== 1'b0 || eng_buf !== 1'b1) begin errors++; $display("FAIL rbusy_bufs got disp %b eng %b exp 0 1", disp_buf, eng_buf); end
    checks++; if (generation !== 16'd0) begin errors++; $display("FAIL rbusy_generation got %0d exp 0", generation); end
    repeat (3) @(negedge pixel_clk);
    reset_n = 1'b1;
    n0 = nstarts;
    repeat (10) @(negedge pixel_clk);
    checks++; if (nstarts !== n0) begin errors++; $display("FAIL rbusy_spurious_start got %0d exp %0d", nstarts, n0); end
    checks++; if (eif.gen_busy !== 1'b0) begin errors++; $display("FAIL rbusy_idle_after got %b exp 0", eif.gen_busy); end
    vsync = 1'b1;
    repeat (5) @(negedge pixel_clk);
    do_frame(-1);
    checks++; if (nstarts - n0 !== 1) begin errors++; $display("FAIL rbusy_restart got %0d exp 1", nstarts - n0); end
    eif.eng_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b1; inside_video = 1'b0; run = 1'b0;
    step = 1'b0; speed = '0; eif.eng_req = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_speed2();
    test_overrun();
    test_grant();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gol_frame_scheduler.md
GOL_FRAME_SCHEDULER -- requirements
Module: gol_frame_scheduler

Interface
REQ-001 SHALL have parameter SPEED_W, default 4, width of speed input and frame counter.
REQ-002 SHALL have parameter GEN_W, default 16, width of generation counter.
REQ-003 SHALL have port pixel_clk  input  1  sole clock, 25 MHz pixel clock; all state rises on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset; one clock and this reset are the only clocking/reset inputs.
REQ-005 SHALL have port vsync  input  1  vertical sync from timing generator, active low.
REQ-006 SHALL have port inside_video  input  1  high while the timing generator is in the active display area.
REQ-007 SHALL have port run  input  1  level; free-running evolution enable, already debounced and synchronous.
REQ-008 SHALL have port step  input  1  one-cycle pulse requesting a single generation.
REQ-009 SHALL have port speed  input  SPEED_W  frames per generation minus one.
REQ-010 SHALL have port gen_done  input  1  one-cycle pulse from the update engine when a generation is written.
REQ-011 SHALL have port eng_req  input  1  update engine requests grid-memory access this cycle.
REQ-012 SHALL have port gen_start  output  1  one-cycle pulse launching the update engine.
REQ-013 SHALL have port gen_busy  output  1  high from gen_start until gen_done.
REQ-014 SHALL have port eng_gnt  output  1  grid-memory grant to the update engine.
REQ-015 SHALL have port disp_buf  output  1  grid buffer read by the display; eng_buf  output  1  buffer written by the engine, always ~disp_buf.
REQ-016 SHALL have port generation  output  GEN_W  count of completed, displayed generations.
REQ-017 SHALL have port overrun  output  1  sticky flag: a scheduled generation was due while the previous one was unfinished.

Function
REQ-018 frame_tick SHALL be a one-cycle internal pulse on the first pixel_clk where registered vsync was 1 and current vsync is 0; vsync register resets to 0 so no tick follows reset release.
REQ-019 step SHALL set a step_pending latch; latch clears only when a trigger is taken.
REQ-020 frame counter SHALL increment on frame_tick when run=1 and the FSM is not in START/BUSY, clear when a trigger is taken, and hold when run=0.
REQ-021 trigger SHALL be true on frame_tick when step_pending=1 or (run=1 and frame counter == speed).
REQ-022 FSM states SHALL be IDLE, START, BUSY, SWAP_WAIT; reset state IDLE.
REQ-023 IDLE: on trigger -> START; otherwise stay.
REQ-024 START: gen_start=1 for exactly this cycle; unconditionally -> BUSY next cycle.
REQ-025 BUSY: on gen_done -> SWAP_WAIT; a gen_done coinciding with frame_tick SHALL still only go to SWAP_WAIT (swap deferred to next frame_tick).
REQ-026 SWAP_WAIT: on frame_tick toggle disp_buf, increment generation (wrap 2^GEN_W-1 -> 0), then -> START if trigger on the same tick, else -> IDLE.
REQ-027 gen_busy SHALL be 1 in START and BUSY, 0 otherwise.
REQ-028 eng_gnt SHALL be combinational: eng_req AND NOT inside_video AND state==BUSY; display always owns memory during active video.
REQ-029 overrun SHALL set on frame_tick in START or BUSY when run=1 and frame counter == speed, and remain set until reset.
REQ-030 gen_done in IDLE, START or SWAP_WAIT SHALL be ignored; deasserting run during BUSY SHALL not abort the generation.
REQ-031 disp_buf SHALL change only on a frame_tick, never mid-frame.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, gen_start=0, gen_busy=0, eng_gnt=0, disp_buf=0, eng_buf=1, generation=0, overrun=0, frame counter=0, step_pending=0, vsync register=0.
REQ-033 reset asserted mid-BUSY SHALL abandon the generation without swap; the first trigger after release restarts from IDLE.

Verification
REQ-034 run=1, speed=0, engine returns gen_done 100 cycles after gen_start: each frame_tick yields SWAP+gen_start; generation increments 1 per frame, disp_buf toggles every frame, overrun=0.
REQ-035 run=0, one step pulse mid-frame: single gen_start at next frame_tick, swap at the following frame_tick, generation=1, no further gen_start.
REQ-036 run=1, speed=2: gen_start on every third frame_tick; generation=3 after 10 frames from reset.
REQ-037 run=1, speed=0, gen_done withheld for 2 frames: overrun=1 and stays 1; disp_buf unchanged until gen_done then next frame_tick.
REQ-038 eng_req=1 held in BUSY: eng_gnt=0 whenever inside_video=1, =1 otherwise; eng_gnt=0 in IDLE/SWAP_WAIT.
REQ-039 reset_n pulsed low during BUSY: all outputs at REQ-032 values asynchronously; no spurious frame_tick on release with vsync=0.
